// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: sized RV64 loads/stores onto 8-byte memory.
// Ports: req_* in, resp_* out, mem_* to/from Data_Memory. Option: MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE, RD, RMW_RD, WR, DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [2:0]  f3_q;
  logic        accept;
  logic [64:0] end_addr;
  logic        oob;
  logic        misal;
  logic        fault;
  logic [63:0] ext;
  logic [63:0] merged;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // 65-bit sum so an address near 2^64 cannot wrap into range.
  assign end_addr = {1'b0, req_addr} + 65'd8;
  assign oob      = end_addr > 65'(MEM_BYTES);

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misal = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misal = req_addr[0];
      2'b10:   misal = |req_addr[1:0];
      2'b11:   misal = |req_addr[2:0];
      default: misal = 1'b0;
    endcase
  end
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    fault = 1'b0;
    if (req_is_load)
      fault = oob || misal || (req_funct3 == 3'b111);
    else if (req_is_store)
      fault = oob || misal || req_funct3[2];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault || !(req_is_load || req_is_store))
            state_nx = DONE;
          else if (req_is_load)
            state_nx = RD;
          else if (req_funct3 == 3'b011)
            state_nx = WR;
          else
            state_nx = RMW_RD;
        end
      end
      RD:      state_nx = DONE;
      RMW_RD:  state_nx = WR;
      WR:      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ext = 64'd0;
    case (f3_q)
      3'b000: ext = {{56{mem_read_data[7]}}, mem_read_data[7:0]};
      3'b001: ext = {{48{mem_read_data[15]}}, mem_read_data[15:0]};
      3'b010: ext = {{32{mem_read_data[31]}}, mem_read_data[31:0]};
      3'b011: ext = mem_read_data;
      3'b100: ext = {56'd0, mem_read_data[7:0]};
      3'b101: ext = {48'd0, mem_read_data[15:0]};
      3'b110: ext = {32'd0, mem_read_data[31:0]};
      default: ext = 64'd0;
    endcase
  end

  always_comb begin
    merged = wdata_q;
    case (f3_q)
      3'b000: merged = {mem_read_data[63:8], wdata_q[7:0]};
      3'b001: merged = {mem_read_data[63:16], wdata_q[15:0]};
      3'b010: merged = {mem_read_data[63:32], wdata_q[31:0]};
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      f3_q       <= 3'd0;
      resp_rdata <= 64'd0;
      resp_fault <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        f3_q       <= req_funct3;
        resp_rdata <= 64'd0;
        resp_fault <= fault;
      end
      if (state == RD)
        resp_rdata <= ext;
      if (state == RMW_RD)
        wdata_q <= merged;
    end
  end

  // Memory strobes decode from the state register only, so a reset
  // sampled while in WR still sees mem_write high at that edge.
  assign resp_valid     = (state == DONE);
  assign mem_read       = (state == RD) || (state == RMW_RD);
  assign mem_write      = (state == WR);
  assign mem_addr       = (mem_read || mem_write) ? addr_q : 64'd0;
  assign mem_write_data = mem_write ? wdata_q : 64'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array memory plus
// a byte-level reference model of sized loads/stores.
module tb_mem_access_unit;

  localparam int MB = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_is_load;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic [63:0] mem_addr;
  logic [63:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_read_data;

  logic [7:0] mem [MB];
  logic [7:0] ref_mem [MB];

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int rd_count = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data)
  );

  always_comb begin
    mem_read_data = 64'd0;
    for (int i = 0; i < 8; i++)
      if (mem_addr + 64'(i) < 64'(MB))
        mem_read_data[8*i +: 8] = mem[8'(mem_addr + 64'(i))];
  end

  always @(posedge clk) begin
    if (mem_read) rd_count <= rd_count + 1;
    if (mem_write) begin
      wr_count <= wr_count + 1;
      for (int i = 0; i < 8; i++)
        if (mem_addr + 64'(i) < 64'(MB))
          mem[8'(mem_addr + 64'(i))] <= mem_write_data[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_fault(input logic [63:0] a,
                                     input bit ld, input bit st,
                                     input logic [2:0] f3);
    bit oob;
    bit mis;
    int sz;
    oob = ({1'b0, a} + 65'd8) > 65'(MB);
    sz  = 1 << f3[1:0];
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (a % 64'(sz)) != 0;
`endif
    if (ld) return oob || mis || f3 == 3'b111;
    if (st) return oob || mis || f3[2];
    return 1'b0;
  endfunction

  task automatic do_req(input logic [63:0] a, input logic [63:0] wd,
                        input bit ld, input bit st,
                        input logic [2:0] f3);
    bit f;
    int sz;
    int exp_lat;
    int lat;
    int rd0;
    int wr0;
    logic [63:0] exp_data;
    logic [63:0] v;
    f  = model_fault(a, ld, st, f3);
    sz = 1 << f3[1:0];
    exp_data = 64'd0;
    if (!ld && !st || f) exp_lat = 1;
    else if (ld) exp_lat = 2;
    else if (f3 == 3'b011) exp_lat = 2;
    else exp_lat = 3;
    if (ld && !f) begin
      v = 64'd0;
      for (int i = 0; i < sz; i++)
        v = v + (64'(ref_mem[int'(a) + i]) << (8 * i));
      if (!f3[2] && sz < 8 && v[8*sz-1])
        v = v | ~((64'd1 << (8 * sz)) - 64'd1);
      exp_data = v;
    end
    if (st && !ld && !f)
      for (int i = 0; i < sz; i++)
        ref_mem[int'(a) + i] = wd[8*i +: 8];

    @(negedge clk);
    req_valid    = 1'b1;
    req_addr     = a;
    req_wdata    = wd;
    req_is_load  = ld;
    req_is_store = st;
    req_funct3   = f3;
    chk("ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    rd0 = rd_count;
    wr0 = wr_count;
    req_valid    = 1'b0;
    req_addr     = {$urandom, $urandom};
    req_wdata    = {$urandom, $urandom};
    req_is_load  = 1'($urandom);
    req_is_store = 1'($urandom);
    req_funct3   = 3'($urandom);
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("fault", 64'(resp_fault), 64'(f));
    chk("rdata", resp_rdata, exp_data);
    chk("writes", 64'(wr_count - wr0), 64'(st && !ld && !f));
    chk("reads", 64'(rd_count - rd0),
        64'((ld || st && f3 != 3'b011) && !f));
  endtask

  initial begin
    int nmis;
    logic [63:0] a;
    for (int i = 0; i < MB; i++) begin
      mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    mem[0] = 8'd2; ref_mem[0] = 8'd2;
    mem[8] = 8'd4; ref_mem[8] = 8'd4;
    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_is_load = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_fault", 64'(resp_fault), 64'd0);
    chk("rst_memw", 64'(mem_write), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_idle", 64'(req_ready), 64'd1);

    do_req(64'd0, 64'd0, 1, 0, 3'b000);
    chk("lb0", resp_rdata, 64'd2);
    do_req(64'd8, 64'hFF, 0, 1, 3'b000);
    do_req(64'd8, 64'd0, 1, 0, 3'b011);
    chk("ld8", resp_rdata, 64'hFF);
    do_req(64'd8, 64'd0, 1, 0, 3'b000);
    chk("lb8", resp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(64'd8, 64'd0, 1, 0, 3'b100);
    chk("lbu8", resp_rdata, 64'hFF);
    do_req(64'd16, 64'h1122334455667788, 0, 1, 3'b011);
    do_req(64'd16, 64'd0, 1, 0, 3'b010);
    chk("lw16", resp_rdata, 64'h55667788);
    do_req(64'd18, 64'd0, 1, 0, 3'b101);
    chk("lhu18", resp_rdata, 64'h5566);
    do_req(64'd22, 64'd0, 1, 0, 3'b001);
    do_req(64'd20, 64'd0, 1, 0, 3'b010);
    do_req(64'd250, 64'hDEAD, 0, 1, 3'b011);
    chk("sd250", 64'(resp_fault), 64'd1);
    do_req(64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1, 0, 3'b011);
    chk("ldwrap", 64'(resp_fault), 64'd1);
    do_req(64'd2, 64'd0, 1, 0, 3'b010);
    do_req(64'd40, 64'd0, 0, 0, 3'b000);

    // Reset while the sb is in its read half: nothing may commit.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'd0; req_wdata = 64'h55;
    req_is_load = 1'b0; req_is_store = 1'b1; req_funct3 = 3'b000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    nmis = wr_count;
    @(negedge clk);
    chk("rmw_state", 64'(mem_read), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_novalid", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready1", 64'(req_ready), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_quiet", 64'(resp_valid), 64'd0);
    end
    chk("rst_nowrite", 64'(wr_count - nmis), 64'd0);
    chk("rst_byte0", 64'(mem[0]), 64'd2);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       a = {$urandom, $urandom};
        1:       a = 64'($urandom_range(240, 260));
        default: a = 64'($urandom_range(0, 248));
      endcase
      if ($urandom_range(0, 1) == 0) a = a & ~64'h7;
      do_req(a, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
             3'($urandom));
    end

    nmis = 0;
    for (int i = 0; i < MB; i++)
      if (mem[i] !== ref_mem[i]) nmis++;
    chk("mem_image", 64'(nmis), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
